// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive safety checker for the north lamp outputs
// of a traffic-light controller. Locks onto the red->green->yellow sequence,
// measures how long each colour dwells, raises sticky one-hot / sequence /
// timing error flags and counts complete error-free cycles.
module traffic_light_monitor #(
    parameter int RED_CYC = 10,
    parameter int GRN_CYC = 8,
    parameter int YEL_CYC = 3,
    parameter int CNT_W   = 8,
    parameter int CYC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             N_R,
    input  logic             N_Y,
    input  logic             N_G,
    input  logic             err_clr,
    output logic             in_sync,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             err_time,
    output logic [CYC_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {ST_SYNC, ST_RED, ST_GRN, ST_YEL} state_t;
    typedef enum logic [1:0] {COL_NONE, COL_R, COL_G, COL_Y} colour_t;

    localparam logic [CNT_W-1:0] RED_DUR = CNT_W'(RED_CYC);
    localparam logic [CNT_W-1:0] GRN_DUR = CNT_W'(GRN_CYC);
    localparam logic [CNT_W-1:0] YEL_DUR = CNT_W'(YEL_CYC);

    state_t             r_state;
    colour_t            r_prev;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_clean;
    logic               r_err_onehot;
    logic               r_err_seq;
    logic               r_err_time;
    logic [CYC_W-1:0]   r_cycle_cnt;

    colour_t            w_colour;
    logic [CNT_W-1:0]   w_dur;
    colour_t            w_same_colour;
    colour_t            w_next_colour;
    state_t             w_adv_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_set_onehot;
    logic               w_set_seq;
    logic               w_set_time;
    logic               w_cycle_inc;
    logic               w_clean_next;
    logic               w_wrap;
    logic               w_enter_grn;

    // Decode the lamp triple into a single colour; anything not one-hot is NONE.
    always_comb begin
        w_colour = COL_NONE;
        case ({N_R, N_Y, N_G})
            3'b100:  w_colour = COL_R;
            3'b010:  w_colour = COL_Y;
            3'b001:  w_colour = COL_G;
            default: w_colour = COL_NONE;
        endcase
    end

    // Per-state dwell target, the colour that continues the dwell and the legal successor.
    always_comb begin
        w_dur         = '0;
        w_same_colour = COL_NONE;
        w_next_colour = COL_NONE;
        w_adv_state   = ST_SYNC;
        case (r_state)
            ST_RED: begin
                w_dur = RED_DUR; w_same_colour = COL_R; w_next_colour = COL_G; w_adv_state = ST_GRN;
            end
            ST_GRN: begin
                w_dur = GRN_DUR; w_same_colour = COL_G; w_next_colour = COL_Y; w_adv_state = ST_YEL;
            end
            ST_YEL: begin
                w_dur = YEL_DUR; w_same_colour = COL_Y; w_next_colour = COL_R; w_adv_state = ST_RED;
            end
            default: begin
                w_dur = '0; w_same_colour = COL_NONE; w_next_colour = COL_NONE; w_adv_state = ST_SYNC;
            end
        endcase
    end

    // Next-state logic: sequence tracking, dwell counting and error detection for this edge.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_set_onehot = 1'b0;
        w_set_seq    = 1'b0;
        w_set_time   = 1'b0;
        w_cycle_inc  = 1'b0;
        w_wrap       = 1'b0;
        w_enter_grn  = 1'b0;
        if (w_colour == COL_NONE) begin
            w_set_onehot = 1'b1;
            w_next_state = ST_SYNC;
        end else if (r_state == ST_SYNC) begin
            if (r_prev == COL_R && w_colour == COL_G) begin
                w_next_state = ST_GRN;
                w_cnt_next   = CNT_W'(1);
                w_enter_grn  = 1'b1;
            end
        end else if (w_colour == w_same_colour) begin
            if (r_cnt == w_dur) begin
                w_set_time   = 1'b1;
                w_next_state = ST_SYNC;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end else if (w_colour == w_next_colour) begin
            w_set_time   = (r_cnt != w_dur);
            w_next_state = w_adv_state;
            w_cnt_next   = CNT_W'(1);
            if (r_state == ST_YEL) begin
                w_wrap      = 1'b1;
                w_cycle_inc = r_clean && (r_cnt == w_dur);
            end
        end else begin
            w_set_seq    = 1'b1;
            w_next_state = ST_SYNC;
        end

        if (w_wrap || w_enter_grn) begin
            w_clean_next = 1'b1;
        end else if (w_set_onehot || w_set_seq || w_set_time) begin
            w_clean_next = 1'b0;
        end else begin
            w_clean_next = r_clean;
        end
    end

    // State register plus dwell counter, sticky flags and saturating good-cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_SYNC;
            r_prev       <= COL_NONE;
            r_cnt        <= '0;
            r_clean      <= 1'b0;
            r_err_onehot <= 1'b0;
            r_err_seq    <= 1'b0;
            r_err_time   <= 1'b0;
            r_cycle_cnt  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_prev       <= w_colour;
            r_cnt        <= w_cnt_next;
            r_clean      <= w_clean_next;
            r_err_onehot <= w_set_onehot | (r_err_onehot & ~err_clr);
            r_err_seq    <= w_set_seq    | (r_err_seq    & ~err_clr);
            r_err_time   <= w_set_time   | (r_err_time   & ~err_clr);
            if (w_cycle_inc && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
            end
        end
    end

    // Output decode: lock indication follows the state, everything else mirrors registers.
    always_comb begin
        in_sync    = (r_state != ST_SYNC);
        err_onehot = r_err_onehot;
        err_seq    = r_err_seq;
        err_time   = r_err_time;
        cycle_cnt  = r_cycle_cnt;
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed plus randomized lamp stimulus, checked
// edge by edge against a colour-level reference model of the monitor.
module tb_traffic_light_monitor;

    localparam int RED_CYC = 10;
    localparam int GRN_CYC = 8;
    localparam int YEL_CYC = 3;
    localparam int CNT_W   = 8;
    localparam int CYC_W   = 16;
    localparam int CYC_MAX = (1 << CYC_W) - 1;

    // Colour indices in sequence order so the legal successor is (c+1)%3.
    localparam int C_R = 0;
    localparam int C_G = 1;
    localparam int C_Y = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             nR, nY, nG;
    logic             errClr;
    logic             inSync, errOnehot, errSeq, errTime;
    logic [CYC_W-1:0] cycleCnt;

    int assertCount = 0;
    int failCount   = 0;

    int durTab [3] = '{RED_CYC, GRN_CYC, YEL_CYC};

    // Reference model state, kept in colour terms rather than FSM encoding.
    bit mLocked;
    int mCur;
    int mDwell;
    int mPrev;
    int mCycles;
    bit mClean;
    bit mErrOne, mErrSeq, mErrTime;

    traffic_light_monitor #(
        .RED_CYC(RED_CYC), .GRN_CYC(GRN_CYC), .YEL_CYC(YEL_CYC),
        .CNT_W(CNT_W), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .rst(rst), .N_R(nR), .N_Y(nY), .N_G(nG), .err_clr(errClr),
        .in_sync(inSync), .err_onehot(errOnehot), .err_seq(errSeq),
        .err_time(errTime), .cycle_cnt(cycleCnt)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic int decode(input logic [2:0] lamps);
        case (lamps)
            3'b100:  return C_R;
            3'b001:  return C_G;
            3'b010:  return C_Y;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] colLamps(input int col);
        case (col)
            C_R:     return 3'b100;
            C_G:     return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    function automatic void modelReset();
        mLocked  = 1'b0;
        mCur     = 0;
        mDwell   = 0;
        mPrev    = -1;
        mCycles  = 0;
        mClean   = 1'b0;
        mErrOne  = 1'b0;
        mErrSeq  = 1'b0;
        mErrTime = 1'b0;
    endfunction

    // One clock edge of the monitor's rules, applied to lamps {R,Y,G}.
    function automatic void modelStep(input logic [2:0] lamps, input logic clr);
        int c;
        bit nOne, nSeq, nTime, wrap;
        c = decode(lamps);
        nOne = 0; nSeq = 0; nTime = 0; wrap = 0;
        if (c < 0) begin
            nOne = 1; mLocked = 0;
        end else if (!mLocked) begin
            if (mPrev == C_R && c == C_G) begin
                mLocked = 1; mCur = C_G; mDwell = 1; mClean = 1;
            end
        end else if (c == mCur) begin
            if (mDwell == durTab[mCur]) begin
                nTime = 1; mLocked = 0;
            end else begin
                mDwell++;
            end
        end else if (c == (mCur + 1) % 3) begin
            if (mDwell != durTab[mCur]) nTime = 1;
            if (mCur == C_Y) begin
                wrap = 1;
                if (mClean && !nTime && mCycles < CYC_MAX) mCycles++;
            end
            mCur = c; mDwell = 1;
        end else begin
            nSeq = 1; mLocked = 0;
        end
        if (wrap) mClean = 1;
        else if (nOne || nSeq || nTime) mClean = 0;
        mErrOne  = nOne  | (mErrOne  & !clr);
        mErrSeq  = nSeq  | (mErrSeq  & !clr);
        mErrTime = nTime | (mErrTime & !clr);
        mPrev = c;
    endfunction

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input logic [CYC_W-1:0] obs, input int exp);
        assertCount++;
        assert (obs === CYC_W'(exp)) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkBit("in_sync", inSync, mLocked);
        checkBit("err_onehot", errOnehot, mErrOne);
        checkBit("err_seq", errSeq, mErrSeq);
        checkBit("err_time", errTime, mErrTime);
        checkCount("cycle_cnt", cycleCnt, mCycles);
    endtask

    // Drive one edge worth of lamps at the falling edge, step the model, check at the next falling edge.
    task automatic applyStimulus(input logic [2:0] lamps, input logic clr);
        {nR, nY, nG} = lamps;
        errClr = clr;
        @(posedge clk);
        modelStep(lamps, clr);
        @(negedge clk);
        checkOutput();
        errClr = 1'b0;
    endtask

    task automatic drivePhase(input int col, input int n);
        for (int i = 0; i < n; i++) applyStimulus(colLamps(col), 1'b0);
    endtask

    task automatic goldenCycle();
        drivePhase(C_G, GRN_CYC);
        drivePhase(C_Y, YEL_CYC);
        drivePhase(C_R, RED_CYC);
    endtask

    initial begin
        int saved;
        int col;
        int len;
        logic [2:0] lamps;
        logic clr;

        rst = 1'b1; errClr = 1'b0; {nR, nY, nG} = 3'b000;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput();
        rst = 1'b0;

        $display("[TB] golden sequence");
        drivePhase(C_R, RED_CYC);
        drivePhase(C_G, 1);
        checkBit("lock_after_rg", inSync, 1'b1);
        drivePhase(C_G, GRN_CYC - 1);
        drivePhase(C_Y, YEL_CYC);
        drivePhase(C_R, RED_CYC);
        checkCount("golden_cyc1", cycleCnt, 1);
        goldenCycle();
        checkCount("golden_cyc2", cycleCnt, 2);
        checkBit("golden_no_err", errOnehot | errSeq | errTime, 1'b0);

        $display("[TB] sequence error from RED");
        drivePhase(C_Y, 1);
        checkBit("seq_err", errSeq, 1'b1);
        checkBit("seq_unlock", inSync, 1'b0);
        saved = mCycles;
        drivePhase(C_R, 3);
        drivePhase(C_G, 1);
        checkBit("seq_relock", inSync, 1'b1);
        checkCount("seq_resync_cyc", cycleCnt, saved);
        drivePhase(C_G, GRN_CYC - 1);
        drivePhase(C_Y, YEL_CYC);
        drivePhase(C_R, RED_CYC);

        $display("[TB] one-hot errors and clear");
        applyStimulus(3'b101, 1'b0);
        checkBit("onehot_rg", errOnehot, 1'b1);
        checkBit("onehot_unlock", inSync, 1'b0);
        applyStimulus(colLamps(C_R), 1'b1);
        checkBit("clr_all", errOnehot | errSeq | errTime, 1'b0);
        drivePhase(C_R, 1);
        goldenCycle();
        drivePhase(C_G, GRN_CYC);
        drivePhase(C_Y, YEL_CYC);
        applyStimulus(3'b000, 1'b0);
        checkBit("onehot_zero", errOnehot, 1'b1);
        checkBit("onehot_zero_unlock", inSync, 1'b0);

        $display("[TB] dwell timing errors");
        drivePhase(C_R, 3);
        drivePhase(C_G, GRN_CYC + 1);
        checkBit("overrun_time", errTime, 1'b1);
        checkBit("overrun_unlock", inSync, 1'b0);
        applyStimulus(colLamps(C_R), 1'b1);
        drivePhase(C_R, 2);
        drivePhase(C_G, 5);
        drivePhase(C_Y, 1);
        checkBit("short_grn_time", errTime, 1'b1);
        checkBit("short_grn_locked", inSync, 1'b1);
        saved = mCycles;
        drivePhase(C_Y, YEL_CYC - 1);
        drivePhase(C_R, 1);
        checkCount("short_grn_no_inc", cycleCnt, saved);
        drivePhase(C_R, RED_CYC - 1);
        goldenCycle();

        $display("[TB] clear colliding with new sequence error");
        applyStimulus(colLamps(C_Y), 1'b1);
        checkBit("clr_vs_seq", errSeq, 1'b1);

        $display("[TB] randomized lamp traffic");
        drivePhase(C_R, 2);
        for (int k = 0; k < 45; k++) begin
            col = k % 3;
            len = durTab[col];
            if ($urandom_range(0, 3) == 0) len = len + int'($urandom_range(0, 2)) - 1;
            if ($urandom_range(0, 11) == 0) col = (col + 2) % 3;
            for (int e = 0; e < len; e++) begin
                lamps = colLamps(col);
                clr = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 24) == 0) lamps = 3'($urandom_range(0, 7));
                applyStimulus(lamps, clr);
            end
        end

        $display("[TB] asynchronous reset mid-green");
        drivePhase(C_R, RED_CYC);
        for (int k = 0; k < 4; k++) goldenCycle();
        checkBit("pre_reset_cycles", (cycleCnt >= CYC_W'(3)), 1'b1);
        drivePhase(C_G, 4);
        #2 rst = 1'b1;
        #1 modelReset();
        checkOutput();
        checkBit("async_unlock", inSync, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drivePhase(C_R, RED_CYC);
        drivePhase(C_G, 1);
        checkBit("relock_after_rst", inSync, 1'b1);
        drivePhase(C_G, GRN_CYC - 1);
        drivePhase(C_Y, YEL_CYC);
        drivePhase(C_R, 1);
        checkCount("post_rst_cyc", cycleCnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
